uart_rx_byte_receiver: RTL and testbench
========================================

Name: uart_rx_byte_receiver

Overview:
Receives asynchronous 8N1 serial data on the board's uart_rx pin and produces parallel bytes for lab_top. It sits between the top-level uart_rx pad and lab logic. Outputs use a valid/ready handshake. It also provides framing-error and overrun status, for later use by the self-diagnostics path.

Parameters:
clk_mhz, 25, system clock frequency in MHz.
baud_rate, 115200, serial bit rate in bits per second.
bit_period, (clk_mhz*1000000 + baud_rate/2)/baud_rate, clocks per bit, derived (217 at defaults); must be >= 4.
half_period, bit_period/2, clocks from start-edge detect to mid-start sample, derived.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous reset, active-high.
rx  input  1  raw asynchronous serial line; idles high.
ready  input  1  consumer accepts data when ready && valid.
data  output  8  received byte, LSB first on the line; stable while valid=1.
valid  output  1  byte available; held until accepted.
framing_error  output  1  one-cycle pulse when the stop bit samples low.
overrun  output  1  sticky; set when a byte is dropped; cleared only by rst.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous and active-high, with ports clk and rst.
- Reset values: data=0, valid=0, framing_error=0, overrun=0, busy=0, state=IDLE, armed=0. The synchronizer flops reset to 1.
- Input synchronizer: rx passes through 2 flops to form rx_s, giving 2 cycles of latency. All decisions use rx_s only.
- Arming: the armed flag sets on the first cycle rx_s=1 after reset. No start bit is detected while armed=0, so a line held low through reset is ignored.
- Bit counter: one down-counter, cnt, which is wide enough for bit_period-1. A "tick" is the cycle in which cnt==0.
- FSM states:
  - IDLE: when armed && rx_s==0, go to START and set cnt=half_period-1.
  - START: on tick, if rx_s==0, go to DATA with cnt=bit_period-1 and idx=0. If rx_s==1 (glitch), return to IDLE with no output.
  - DATA: on tick, shreg <= {rx_s, shreg[7:1]}, cnt=bit_period-1, idx++. After the 8th sample (idx==7), go to STOP.
  - STOP: on tick, sample rx_s.
    - If rx_s=1, the frame is good: go to IDLE. The byte is delivered per the handshake rules below.
    - If rx_s=0, pulse framing_error for 1 cycle, do not deliver the byte, and go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. This covers a line held low or a break condition.
- Re-arming: the FSM returns to IDLE at mid-stop-bit, so back-to-back frames with a single stop bit are received without loss.
- Handshake:
  - On a good stop tick: if valid==0, or ready==1 in the same cycle, then data<=shreg and valid<=1 on the next edge.
  - Otherwise the new byte is discarded, data is unchanged, and overrun<=1.
  - When ready && valid with no simultaneous completion, valid<=0 on the next edge.
  - Simultaneous accept and completion: the old byte is consumed, the new byte is loaded, and valid stays 1.
- Latency: from the rx falling edge at the pin, valid rises 2 + half_period + 9*bit_period + 1 cycles later, within ±1 cycle.
- Sampling tolerance: each bit is sampled mid-bit, so baud mismatch up to about ±4% is tolerated over 10 bits.
- Reset mid-frame: the FSM returns to IDLE immediately and the partial byte is discarded. armed=0, so reception resumes only after the line is seen high.
- The shift register and idx have no reset requirement beyond determinism; implement them with reset to 0.

Test Plan:
Bench parameters are clk_mhz=1 and baud_rate=100000, giving bit_period=10 and half_period=5.
1. Single frame 0xA5 with ready=1 -> valid is high for exactly 1 cycle with data=0xA5, about 98 cycles after the start edge (tolerance ±1). framing_error=0 and overrun=0.
2. Back-to-back frames 0x00, 0xFF, 0x55 (one stop bit each), with ready held 0 and the consumer accepting each byte within 50 cycles -> three bytes received in order with no loss.
3. Glitch: rx low for 3 cycles, then high -> FSM returns to IDLE from START. valid never asserts and busy drops within 6 cycles.
4. Frame 0x3C with the stop bit driven low, line held low for 40 cycles, then the frame 0x81 -> one framing_error pulse and no valid for 0x3C. busy stays high through BREAK, then 0x81 is received correctly.
5. ready=0 and two frames 0x11, 0x22 -> valid=1 with data=0x11 and overrun=1. After ready pulses, valid=0 and overrun remains 1 until rst.
6. Assert rst during the DATA bits of 0x77 with rx held low across reset -> no byte is produced and no start is detected until rx goes high. The next frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_byte_receiver.sv
// uart_rx_byte_receiver
// 8N1 serial receiver: two-flop input synchronizer, mid-bit sampling FSM,
// valid/ready byte output, one-cycle framing-error pulse and sticky overrun.
module uart_rx_byte_receiver #(
  parameter int clk_mhz   = 25,
  parameter int baud_rate = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  // Clocks per bit (rounded) and the offset from start edge to mid-start.
  localparam int bit_period  = (clk_mhz * 1000000 + baud_rate / 2) / baud_rate;
  localparam int half_period = bit_period / 2;
  localparam int CNT_W       = $clog2(bit_period);

  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(bit_period - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(half_period - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic             r_rx_meta;
  logic             r_rx_s;
  logic [1:0]       r_fill;
  logic             r_armed;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shreg;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_framing_error;
  logic             r_overrun;
  logic             w_tick;

  assign w_tick        = (r_cnt == '0);
  assign data          = r_data;
  assign valid         = r_valid;
  assign framing_error = r_framing_error;
  assign overrun       = r_overrun;
  assign busy          = (r_state != S_IDLE);

  // Synchronize rx and arm once the line has genuinely been seen high.
  // The synchronizer flops reset to 1, so r_fill marks when r_rx_s holds a
  // real line sample; otherwise the reset value would arm the receiver and
  // a line held low through reset would look like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_fill    <= 2'b00;
      r_armed   <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_fill    <= {r_fill[0], 1'b1};
      if (r_fill[1] && r_rx_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Frame FSM, bit timing, shift register and output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_idx           <= 3'd0;
      r_shreg         <= 8'h00;
      r_data          <= 8'h00;
      r_valid         <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_framing_error <= 1'b0;
      // Consumer accept; a simultaneous completion below overrides this.
      if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (r_armed && !r_rx_s) begin
            r_state <= S_START;
            r_cnt   <= HALF_M1;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (!r_rx_s) begin
              r_state <= S_DATA;
              r_cnt   <= BIT_M1;
              r_idx   <= 3'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shreg <= {r_rx_s, r_shreg[7:1]};
            r_cnt   <= BIT_M1;
            r_idx   <= r_idx + 1'b1;
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_rx_s) begin
              // Back to IDLE at mid-stop so the next start edge is not missed.
              r_state <= S_IDLE;
              if (!r_valid || ready) begin
                r_data  <= r_shreg;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_framing_error <= 1'b1;
              r_state         <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_BREAK: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte_receiver.sv
// Testbench for uart_rx_byte_receiver: directed frames, expected bytes are
// queued at stimulus time and popped by a monitor on every accepted byte.
`timescale 1ns/1ps
module tb_uart_rx_byte_receiver;

  localparam int BIT = 10;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 0;        // 0: ready=1, 1: accept 20 cycles after valid, 2: ready=0 except pulses
  int pulse_req = 0;
  int fe_count = 0;
  int valid_hi = 0;
  int valid_rises = 0;
  int last_rise_cyc = 0;
  int start_cyc = 0;
  logic [7:0] exp_q[$];

  uart_rx_byte_receiver #(.clk_mhz(1), .baud_rate(100000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .ready(ready), .data(data), .valid(valid),
    .framing_error(framing_error), .overrun(overrun), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Consumer: drives ready according to the selected mode.
  initial begin
    int wc;
    int pulse_done;
    wc = 0;
    pulse_done = 0;
    ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: ready = 1'b1;
        1: begin
          if (ready) begin
            ready = 1'b0;
          end else if (valid) begin
            wc++;
            if (wc >= 20) begin
              ready = 1'b1;
              wc = 0;
            end
          end
        end
        default: begin
          if (pulse_req != pulse_done) begin
            ready = 1'b1;
            pulse_done++;
          end else begin
            ready = 1'b0;
          end
        end
      endcase
    end
  end

  // Monitor: pops and compares on every accepted byte; tallies status pulses.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (framing_error) fe_count++;
      if (valid) valid_hi++;
      if (valid && !prev_valid) begin
        valid_rises++;
        last_rise_cyc = cyc;
      end
      if (valid && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte got %02h required none", data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (data !== e) begin
            errors++;
            $display("FAIL byte_data got %02h required %02h", data, e);
          end else begin
            $display("byte accepted %02h at cycle %0d", data, cyc);
          end
        end
      end
    end
    prev_valid = valid;
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit push);
    if (push) exp_q.push_back(b);
    start_cyc = cyc;
    rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(BIT);
    end
    rx = stop_bit;
    step(BIT);
    rx = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int v0, f0, bseen, lat;
    rx  = 1'b1;
    rst = 1'b1;
    step(4);
    check("reset_data", int'(data), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_fe", int'(framing_error), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    step(10);

    // 1: single frame, ready=1
    mode = 0;
    valid_hi = 0;
    v0 = valid_rises;
    send_frame(8'hA5, 1'b1, 1);
    step(15);
    lat = last_rise_cyc - start_cyc;
    check("t1_valid_rises", valid_rises - v0, 1);
    check("t1_valid_cycles", valid_hi, 1);
    checks++;
    if (lat < 97 || lat > 99) begin
      errors++;
      $display("FAIL t1_latency got %0d required 98+-1", lat);
    end
    check("t1_fe", fe_count, 0);
    check("t1_overrun", int'(overrun), 0);
    $display("test1 done latency %0d", lat);

    // 2: back-to-back frames with delayed consumer
    mode = 1;
    send_frame(8'h00, 1'b1, 1);
    send_frame(8'hFF, 1'b1, 1);
    send_frame(8'h55, 1'b1, 1);
    drain("t2_queue_drained");
    check("t2_overrun", int'(overrun), 0);
    mode = 0;
    step(10);

    // 3: start glitch
    v0 = valid_rises;
    rx = 1'b0;
    step(3);
    check("t3_busy_seen", int'(busy), 1);
    rx = 1'b1;
    bseen = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (!busy) begin
        bseen = 0;
        break;
      end
    end
    check("t3_busy_dropped", bseen, 0);
    step(20);
    check("t3_no_valid", valid_rises - v0, 0);

    // 4: framing error, break, then good frame
    f0 = fe_count;
    v0 = valid_rises;
    send_frame(8'h3C, 1'b0, 0);
    rx = 1'b0;
    step(20);
    check("t4_busy_in_break", int'(busy), 1);
    step(10);
    rx = 1'b1;
    step(10);
    check("t4_fe_pulses", fe_count - f0, 1);
    check("t4_no_valid", valid_rises - v0, 0);
    send_frame(8'h81, 1'b1, 1);
    drain("t4_queue_drained");
    check("t4_overrun", int'(overrun), 0);

    // 5: overrun with ready held low
    mode = 2;
    step(5);
    send_frame(8'h11, 1'b1, 1);
    send_frame(8'h22, 1'b1, 0);
    step(20);
    check("t5_valid", int'(valid), 1);
    check("t5_data", int'(data), 8'h11);
    check("t5_overrun", int'(overrun), 1);
    pulse_req++;
    step(4);
    check("t5_valid_after_accept", int'(valid), 0);
    check("t5_overrun_sticky", int'(overrun), 1);
    check("t5_queue_empty", exp_q.size(), 0);
    mode = 0;
    step(10);

    // 6: reset mid-frame with rx held low
    v0 = valid_rises;
    rx = 1'b0;
    step(BIT);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;
      step(BIT);
    end
    rx = 1'b0;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    bseen = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (busy) bseen = 1;
    end
    check("t6_no_start_while_low", bseen, 0);
    check("t6_overrun_cleared", int'(overrun), 0);
    check("t6_valid", int'(valid), 0);
    rx = 1'b1;
    step(20);
    send_frame(8'h5A, 1'b1, 1);
    drain("t6_queue_drained");
    check("t6_one_byte", valid_rises - v0, 1);

    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
